axis_aximm_slave_mem: RTL

//   AXI4 full-protocol slave memory responder: the far end of the M00_AXI master in axis_aximm.

---
 rtl/axis_aximm_slave_mem_if.sv | 66 ++++++
 rtl/axis_aximm_slave_mem.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_aximm_slave_mem_if.sv
// AXI4 full-protocol bus bundle between the axis_aximm master and its slave memory.
interface axis_aximm_slave_mem_if #(
    parameter int ID_W   = 1,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axis_aximm_slave_mem.sv
// AXI4 slave memory: independent write (AW/W/B) and read (AR/R) engines, one burst
// outstanding each, INCR/FIXED bursts into a byte-writable register-array RAM.
module axis_aximm_slave_mem #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_MEM_DEPTH        = 1024
) (
    input logic                    ACLK,
    input logic                    ARESETN,
    axis_aximm_slave_mem_if.slave  s_axi
);
    localparam int IDW      = C_S_AXI_ID_WIDTH;
    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int STRB_W   = DW / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(C_MEM_DEPTH);
    localparam logic [AW-1:0] SPAN     = AW'(C_MEM_DEPTH * STRB_W);
    localparam logic [AW-1:0] STEP     = AW'(STRB_W);
    localparam logic [2:0]    SIZE_NAT = 3'(ADDR_LSB);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA} rstate_t;

    function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] a);
        return a[ADDR_LSB +: IDX_W];
    endfunction

    function automatic logic in_span(input logic [AW-1:0] a);
        return a < SPAN;
    endfunction

    logic [DW-1:0] mem [C_MEM_DEPTH];

    // Write engine state
    wstate_t        wst_q, wst_d;
    logic [IDW-1:0] wid_q, wid_d, bid_q, bid_d;
    logic [AW-1:0]  waddr_q, waddr_d;
    logic [7:0]     wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic           wincr_q, wincr_d, werr_q, werr_d;
    logic           awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]     bresp_q, bresp_d;
    logic           mem_we, w_in_rng, w_final;

    // Read engine state
    rstate_t        rst_q, rst_d;
    logic [IDW-1:0] rid_q, rid_d;
    logic [AW-1:0]  raddr_q, raddr_d, rd_addr;
    logic [7:0]     rlen_q, rlen_d, rcnt_q, rcnt_d, rcnt_nxt;
    logic           rincr_q, rincr_d, rcfg_q, rcfg_d;
    logic           arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [DW-1:0]  rdata_q, rdata_d, rd_word;
    logic [1:0]     rresp_q, rresp_d;
    logic           rd_load, rd_done, rd_cfg, rd_last, rd_err;

    // Write FSM: address latch, per-beat range/WLAST checking, response hold
    always_comb begin
        wst_d     = wst_q;
        wid_d     = wid_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wincr_d   = wincr_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        bid_d     = bid_q;
        mem_we    = 1'b0;
        w_in_rng  = in_span(waddr_q);
        w_final   = (wcnt_q == wlen_q);
        unique case (wst_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (s_axi.awvalid && awready_q) begin
                    wid_d     = s_axi.awid;
                    waddr_d   = s_axi.awaddr;
                    wlen_d    = s_axi.awlen;
                    wincr_d   = (s_axi.awburst == 2'b01);
                    wcnt_d    = 8'd0;
                    werr_d    = (s_axi.awsize != SIZE_NAT) || s_axi.awburst[1];
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    wst_d     = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi.wvalid && wready_q) begin
                    // The error flag as it stood before this beat gates the write.
                    mem_we = !werr_q && w_in_rng;
                    werr_d = werr_q || !w_in_rng || (s_axi.wlast != w_final);
                    if (w_final) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bresp_d  = werr_d ? 2'b10 : 2'b00;
                        bid_d    = wid_q;
                        wst_d    = W_RESP;
                    end else begin
                        wcnt_d = wcnt_q + 8'd1;
                        if (wincr_q) begin
                            waddr_d = waddr_q + STEP;
                        end
                    end
                end
            end
            W_RESP: begin
                if (s_axi.bready && bvalid_q) begin
                    bvalid_d = 1'b0;
                    wst_d    = W_IDLE;
                end
            end
            default: wst_d = W_IDLE;
        endcase
    end

    // Write engine registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wst_q     <= W_IDLE;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wincr_q   <= 1'b0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            bid_q     <= '0;
        end else begin
            wst_q     <= wst_d;
            wid_q     <= wid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wincr_q   <= wincr_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
        end
    end

    // RAM byte-lane writes; contents survive reset
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi.wstrb[b]) begin
                    mem[word_idx(waddr_q)][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read FSM: picks which beat address to load and when the burst ends
    always_comb begin
        rst_d     = rst_q;
        rid_d     = rid_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rincr_d   = rincr_q;
        rcfg_d    = rcfg_q;
        rcnt_d    = rcnt_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rd_load   = 1'b0;
        rd_done   = 1'b0;
        rd_addr   = raddr_q;
        rd_cfg    = rcfg_q;
        rd_last   = 1'b0;
        rcnt_nxt  = rcnt_q + 8'd1;
        unique case (rst_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (s_axi.arvalid && arready_q) begin
                    rid_d     = s_axi.arid;
                    rlen_d    = s_axi.arlen;
                    rincr_d   = (s_axi.arburst == 2'b01);
                    rcfg_d    = (s_axi.arsize != SIZE_NAT) || s_axi.arburst[1];
                    rcnt_d    = 8'd0;
                    raddr_d   = s_axi.araddr;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rd_load   = 1'b1;
                    rd_addr   = s_axi.araddr;
                    rd_cfg    = rcfg_d;
                    rd_last   = (s_axi.arlen == 8'd0);
                    rst_d     = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && s_axi.rready) begin
                    if (rlast_q) begin
                        rvalid_d = 1'b0;
                        rd_done  = 1'b1;
                        rst_d    = R_IDLE;
                    end else begin
                        rd_addr = rincr_q ? (raddr_q + STEP) : raddr_q;
                        raddr_d = rd_addr;
                        rcnt_d  = rcnt_nxt;
                        rd_load = 1'b1;
                        rd_last = (rcnt_nxt == rlen_q);
                    end
                end
            end
            default: rst_d = R_IDLE;
        endcase
    end

    assign rd_word = mem[word_idx(rd_addr)];

    // Read beat payload: RAM word or zero with SLVERR for an errored beat
    always_comb begin
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        rlast_d = rlast_q;
        rd_err  = rd_cfg || !in_span(rd_addr);
        if (rd_load) begin
            rdata_d = rd_err ? '0 : rd_word;
            rresp_d = rd_err ? 2'b10 : 2'b00;
            rlast_d = rd_last;
        end else if (rd_done) begin
            rdata_d = '0;
            rresp_d = 2'b00;
            rlast_d = 1'b0;
        end
    end

    // Read engine registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rst_q     <= R_IDLE;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rincr_q   <= 1'b0;
            rcfg_q    <= 1'b0;
            rcnt_q    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            rst_q     <= rst_d;
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rincr_q   <= rincr_d;
            rcfg_q    <= rcfg_d;
            rcnt_q    <= rcnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.bid     = bid_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.rid     = rid_q;
endmodule
